// File: rtl/wb_stage_if.sv
// Signal bundle between the memory stage, data memory, register file and the writeback stage.
// master drives the stage inputs; slave is the writeback stage itself.
interface wb_stage_if;
  logic        enable_halt;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [2:0]  in_funct3;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_dest;
  logic [31:0] rg_wrt_data;
  logic        wb_stall;
  logic [31:0] retired_count;

  modport master (
    output enable_halt, in_valid, in_rd, in_reg_write, in_wb_sel, in_alu_result,
           in_pc_plus4, in_funct3, mem_rsp_valid, mem_rsp_data,
    input  in_ready, rg_wrt_en, rg_wrt_dest, rg_wrt_data, wb_stall, retired_count
  );

  modport slave (
    input  enable_halt, in_valid, in_rd, in_reg_write, in_wb_sel, in_alu_result,
           in_pc_plus4, in_funct3, mem_rsp_valid, mem_rsp_data,
    output in_ready, rg_wrt_en, rg_wrt_dest, rg_wrt_data, wb_stall, retired_count
  );
endinterface

// File: rtl/wb_stage.sv
// RV32 writeback stage: waits for load data, formats it, drives the register-file write port
// and counts retired instructions. Loads park in WAIT_MEM; a response seen under halt parks in PEND.
module wb_stage (
  input logic     clk,
  input logic     rst,
  wb_stage_if.slave bus
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, PEND} state_e;

  state_e              state_q, state_d;
  logic [4:0]          rd_q;
  logic                regw_q;
  logic [2:0]          funct3_q;
  logic [1:0]          off_q;
  logic [DATA_W-1:0]   pdata_q;
  logic                wen_q;
  logic [4:0]          wdest_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   cnt_q;

  logic                xfer;
  logic                latch_ld;
  logic                park;
  logic                issue;
  logic [4:0]          issue_rd;
  logic                issue_regw;
  logic [DATA_W-1:0]   issue_data;
  logic [DATA_W-1:0]   rsp_fmt;

  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] w,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] off);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic [DATA_W-1:0]  res;
    sb = w[{off, 3'b000} +: 8];
    sh = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  res = {{24{sb[7]}}, sb};
      3'b001:  res = {{16{sh[15]}}, sh};
      3'b100:  res = {24'd0, sb};
      3'b101:  res = {16'd0, sh};
      default: res = w;
    endcase
    return res;
  endfunction

  assign bus.in_ready      = (state_q == IDLE) && !bus.enable_halt && !rst;
  assign bus.wb_stall      = (state_q != IDLE);
  assign bus.rg_wrt_en     = wen_q;
  assign bus.rg_wrt_dest   = wdest_q;
  assign bus.rg_wrt_data   = wdata_q;
  assign bus.retired_count = cnt_q;

  assign xfer    = bus.in_valid && bus.in_ready;
  assign rsp_fmt = fmt_load(bus.mem_rsp_data, funct3_q, off_q);

  always_comb begin
    state_d    = state_q;
    latch_ld   = 1'b0;
    park       = 1'b0;
    issue      = 1'b0;
    issue_rd   = rd_q;
    issue_regw = regw_q;
    issue_data = pdata_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (bus.in_wb_sel == 2'b01) begin
            latch_ld = 1'b1;
            state_d  = WAIT_MEM;
          end else begin
            issue      = 1'b1;
            issue_rd   = bus.in_rd;
            issue_regw = bus.in_reg_write;
            issue_data = (bus.in_wb_sel == 2'b10) ? bus.in_pc_plus4 : bus.in_alu_result;
          end
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rsp_valid) begin
          if (bus.enable_halt) begin
            park    = 1'b1;
            state_d = PEND;
          end else begin
            issue      = 1'b1;
            issue_data = rsp_fmt;
            state_d    = IDLE;
          end
        end
      end
      PEND: begin
        if (!bus.enable_halt) begin
          issue   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: write port, counter and FSM register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      wdest_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= issue && issue_regw && (issue_rd != 5'd0);
      if (issue) begin
        wdest_q <= issue_rd;
        wdata_q <= issue_data;
      end
      cnt_q <= cnt_q + {{(DATA_W-1){1'b0}}, issue};
    end
  end

  // Load descriptor and parked data carry no reset; they are only read after being written.
  always_ff @(posedge clk) begin
    if (latch_ld) begin
      rd_q     <= bus.in_rd;
      regw_q   <= bus.in_reg_write;
      funct3_q <= bus.in_funct3;
      off_q    <= bus.in_alu_result[1:0];
    end
    if (park) pdata_q <= rsp_fmt;
  end
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: load-format vector table, hand-written handshake/halt/reset sequences,
// and a randomized run compared against a transaction-level queue model.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_if bus ();
  wb_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] exp;
  } ld_vec_t;

  typedef struct {
    logic [4:0] rd;
    bit         regw;
    int         f3;
    int         off;
  } ld_t;

  typedef struct {
    logic [4:0]  rd;
    bit          regw;
    logic [31:0] data;
  } wr_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.enable_halt   = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_rd         = '0;
    bus.in_reg_write  = 1'b0;
    bus.in_wb_sel     = '0;
    bus.in_alu_result = '0;
    bus.in_pc_plus4   = '0;
    bus.in_funct3     = '0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic present(input logic [4:0] rd, input bit regw, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [2:0] f3);
    bus.in_valid      = 1'b1;
    bus.in_rd         = rd;
    bus.in_reg_write  = regw;
    bus.in_wb_sel     = sel;
    bus.in_alu_result = alu;
    bus.in_pc_plus4   = 32'h0000_1004;
    bus.in_funct3     = f3;
  endtask

  function automatic logic [31:0] ref_fmt(input logic [31:0] w, input int f3, input int off);
    longint v;
    case (f3)
      0: begin v = (longint'(w) >> (8 * off)) & 255; if (v >= 128) v -= 256; end
      4: v = (longint'(w) >> (8 * off)) & 255;
      1: begin v = (longint'(w) >> (16 * (off / 2))) & 65535; if (v >= 32768) v -= 65536; end
      5: v = (longint'(w) >> (16 * (off / 2))) & 65535;
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  ld_vec_t vecs[10];

  initial begin
    ld_t         busy[$];
    wr_t         held[$];
    logic        m_wen;
    logic [4:0]  m_dest;
    logic [31:0] m_data;
    logic [31:0] m_cnt;

    vecs[0] = '{3'b000, 32'h0000_1001, 32'h8081F2F3, 32'hFFFFFFF2};
    vecs[1] = '{3'b100, 32'h0000_1003, 32'h8081F2F3, 32'h00000080};
    vecs[2] = '{3'b001, 32'h0000_1002, 32'h8081F2F3, 32'hFFFF8081};
    vecs[3] = '{3'b101, 32'h0000_1000, 32'h8081F2F3, 32'h0000F2F3};
    vecs[4] = '{3'b010, 32'h0000_1000, 32'h8081F2F3, 32'h8081F2F3};
    vecs[5] = '{3'b001, 32'h0000_1003, 32'h8081F2F3, 32'hFFFF8081};
    vecs[6] = '{3'b101, 32'h0000_1001, 32'h7F01F2F3, 32'h0000F2F3};
    vecs[7] = '{3'b011, 32'h0000_1002, 32'h12345678, 32'h12345678};
    vecs[8] = '{3'b110, 32'h0000_1001, 32'hA5A55A5A, 32'hA5A55A5A};
    vecs[9] = '{3'b000, 32'h0000_1000, 32'h0000007F, 32'h0000007F};

    // Reset state.
    quiet();
    rst = 1'b1;
    #1;
    chk("in_ready_in_rst", bus.in_ready, 1'b0);
    tick();
    tick();
    chk("rst_wen", bus.rg_wrt_en, 1'b0);
    chk("rst_dest", bus.rg_wrt_dest, 5'd0);
    chk("rst_data", bus.rg_wrt_data, 32'd0);
    chk("rst_cnt", bus.retired_count, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_stall", bus.wb_stall, 1'b0);
    chk("rst_ready", bus.in_ready, 1'b1);

    // ALU stream.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      present(5'(i), 1'b1, 2'b00, 32'h11 * i, 3'b010);
      tick();
      chk("alu_wen", bus.rg_wrt_en, 1'b1);
      chk("alu_dest", bus.rg_wrt_dest, 5'(i));
      chk("alu_data", bus.rg_wrt_data, 32'h11 * i);
    end
    quiet();
    tick();
    chk("alu_wen_after", bus.rg_wrt_en, 1'b0);
    chk("alu_cnt", bus.retired_count, 32'd3);
    present(5'd4, 1'b1, 2'b10, 32'h55, 3'b010);
    tick();
    chk("pc4_data", bus.rg_wrt_data, 32'h0000_1004);
    present(5'd4, 1'b1, 2'b11, 32'h77, 3'b010);
    tick();
    chk("rsvd_sel_data", bus.rg_wrt_data, 32'h77);

    // x0 and no-write.
    do_reset();
    present(5'd0, 1'b1, 2'b00, 32'hDEAD, 3'b010);
    tick();
    chk("x0_wen", bus.rg_wrt_en, 1'b0);
    chk("x0_dest", bus.rg_wrt_dest, 5'd0);
    chk("x0_data", bus.rg_wrt_data, 32'hDEAD);
    present(5'd5, 1'b0, 2'b00, 32'h55, 3'b010);
    tick();
    chk("nowr_wen", bus.rg_wrt_en, 1'b0);
    chk("nowr_dest", bus.rg_wrt_dest, 5'd5);
    quiet();
    tick();
    chk("nowr_cnt", bus.retired_count, 32'd2);

    // Load formatting table, response the cycle after acceptance.
    do_reset();
    foreach (vecs[i]) begin
      present(5'd7, 1'b1, 2'b01, vecs[i].addr, vecs[i].f3);
      tick();
      chk("ld_accept_nowen", bus.rg_wrt_en, 1'b0);
      quiet();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = vecs[i].word;
      tick();
      bus.mem_rsp_valid = 1'b0;
      chk($sformatf("ld%0d_wen", i), bus.rg_wrt_en, 1'b1);
      chk($sformatf("ld%0d_data", i), bus.rg_wrt_data, vecs[i].exp);
    end
    chk("ld_cnt", bus.retired_count, 32'd10);

    // Load with a 4-cycle response delay while another instruction is held.
    do_reset();
    present(5'd7, 1'b1, 2'b01, 32'h2000, 3'b010);
    tick();
    present(5'd9, 1'b1, 2'b00, 32'h99, 3'b010);
    for (int c = 0; c < 4; c++) begin
      chk("wait_stall", bus.wb_stall, 1'b1);
      chk("wait_ready", bus.in_ready, 1'b0);
      tick();
      chk("wait_wen", bus.rg_wrt_en, 1'b0);
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hA1B2C3D4;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("wait_wen_rsp", bus.rg_wrt_en, 1'b1);
    chk("wait_dest", bus.rg_wrt_dest, 5'd7);
    chk("wait_data", bus.rg_wrt_data, 32'hA1B2C3D4);
    chk("wait_ready_back", bus.in_ready, 1'b1);
    tick();
    quiet();
    chk("held_dest", bus.rg_wrt_dest, 5'd9);
    chk("held_data", bus.rg_wrt_data, 32'h99);
    chk("held_cnt", bus.retired_count, 32'd2);

    // Response arriving with halt high.
    do_reset();
    present(5'd12, 1'b1, 2'b01, 32'h3000, 3'b010);
    tick();
    quiet();
    bus.enable_halt   = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hCAFEBABE;
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'h0;
    chk("halt_wen0", bus.rg_wrt_en, 1'b0);
    chk("halt_stall", bus.wb_stall, 1'b1);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("halt_wen", bus.rg_wrt_en, 1'b0);
    end
    bus.enable_halt = 1'b0;
    #1;
    chk("pend_ready", bus.in_ready, 1'b0);
    tick();
    chk("pend_wen", bus.rg_wrt_en, 1'b1);
    chk("pend_dest", bus.rg_wrt_dest, 5'd12);
    chk("pend_data", bus.rg_wrt_data, 32'hCAFEBABE);
    chk("pend_ready_after", bus.in_ready, 1'b1);
    tick();
    chk("pend_pulse", bus.rg_wrt_en, 1'b0);
    bus.enable_halt = 1'b1;
    present(5'd3, 1'b1, 2'b00, 32'h42, 3'b010);
    #1;
    chk("idle_halt_ready", bus.in_ready, 1'b0);
    tick();
    chk("idle_halt_wen", bus.rg_wrt_en, 1'b0);
    chk("idle_halt_cnt", bus.retired_count, 32'd1);
    quiet();

    // Reset during WAIT_MEM; stale response afterwards.
    do_reset();
    present(5'd6, 1'b1, 2'b01, 32'h4000, 3'b010);
    tick();
    quiet();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hFFFF_FFFF;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("rml_wen", bus.rg_wrt_en, 1'b0);
    chk("rml_dest", bus.rg_wrt_dest, 5'd0);
    chk("rml_data", bus.rg_wrt_data, 32'd0);
    chk("rml_cnt", bus.retired_count, 32'd0);
    chk("rml_stall", bus.wb_stall, 1'b0);

    // Randomized run against the queue model.
    do_reset();
    m_wen = 1'b0; m_dest = '0; m_data = '0; m_cnt = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        exp_rdy;
      bit          iss;
      wr_t         w;
      bus.enable_halt   = ($urandom_range(0, 4) == 0);
      bus.in_valid      = ($urandom_range(0, 9) < 7);
      bus.in_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.in_reg_write  = ($urandom_range(0, 5) != 0);
      bus.in_wb_sel     = 2'($urandom);
      bus.in_alu_result = $urandom;
      bus.in_pc_plus4   = $urandom;
      bus.in_funct3     = 3'($urandom);
      bus.mem_rsp_valid = ($urandom_range(0, 9) < 4);
      bus.mem_rsp_data  = $urandom;
      #1;
      exp_rdy = (busy.size() == 0) && (held.size() == 0) && !bus.enable_halt;
      chk("rnd_ready", bus.in_ready, exp_rdy);
      chk("rnd_stall", bus.wb_stall, !((busy.size() == 0) && (held.size() == 0)));

      iss = 1'b0;
      w   = '{5'd0, 1'b0, 32'd0};
      if (held.size() > 0) begin
        if (!bus.enable_halt) begin
          w = held.pop_front();
          iss = 1'b1;
        end
      end else if (busy.size() > 0) begin
        if (bus.mem_rsp_valid) begin
          ld_t l;
          l = busy.pop_front();
          w = '{l.rd, l.regw, ref_fmt(bus.mem_rsp_data, l.f3, l.off)};
          if (bus.enable_halt) held.push_back(w);
          else iss = 1'b1;
        end
      end else if (bus.in_valid && exp_rdy) begin
        if (bus.in_wb_sel == 2'b01)
          busy.push_back('{bus.in_rd, bus.in_reg_write, int'(bus.in_funct3),
                           int'(bus.in_alu_result[1:0])});
        else begin
          w = '{bus.in_rd, bus.in_reg_write,
                (bus.in_wb_sel == 2'b10) ? bus.in_pc_plus4 : bus.in_alu_result};
          iss = 1'b1;
        end
      end
      m_wen = iss && w.regw && (w.rd != 0);
      if (iss) begin
        m_dest = w.rd;
        m_data = w.data;
        m_cnt  = m_cnt + 1;
      end

      @(posedge clk);
      #1;
      chk("rnd_wen", bus.rg_wrt_en, m_wen);
      chk("rnd_dest", bus.rg_wrt_dest, m_dest);
      chk("rnd_data", bus.rg_wrt_data, m_data);
      chk("rnd_cnt", bus.retired_count, m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
